// File: rtl/ex_mem_wb_regs_if.sv
// ex_mem_wb_regs_if
//   Groups the EX-stage inputs, data-memory bus and forwarding/write-back
//   outputs of the EX/MEM + MEM/WB pipeline-register block.
//   master : drives EX inputs, flush and memory responses (pipeline/testbench)
//   slave  : the ex_mem_wb_regs block itself
// Signals
//   ex_valid, ex_rd_addr[4:0], ex_reg_write, ex_mem_read, ex_mem_write,
//   ex_alu_result[XLEN], ex_store_data[XLEN], flush      : EX stage -> block
//   dmem_req, dmem_we, dmem_addr[XLEN], dmem_wdata[XLEN] : block -> memory
//   dmem_ready, dmem_rdata[XLEN]                         : memory -> block
//   ex_mem_rd_addr, ex_mem_reg_write, ex_mem_fwd_data    : EX/MEM forwarding
//   mem_wb_rd_addr, mem_wb_reg_write, mem_wb_wr_data     : MEM/WB / regfile write
//   stall                                                : freeze front end
interface ex_mem_wb_regs_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic [4:0]      ex_rd_addr;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic [XLEN-1:0] ex_alu_result;
    logic [XLEN-1:0] ex_store_data;
    logic            flush;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;

    logic [4:0]      ex_mem_rd_addr;
    logic            ex_mem_reg_write;
    logic [XLEN-1:0] ex_mem_fwd_data;
    logic [4:0]      mem_wb_rd_addr;
    logic            mem_wb_reg_write;
    logic [XLEN-1:0] mem_wb_wr_data;
    logic            stall;

    modport master (
        output ex_valid, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_alu_result, ex_store_data, flush, dmem_ready, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
               ex_mem_rd_addr, ex_mem_reg_write, ex_mem_fwd_data,
               mem_wb_rd_addr, mem_wb_reg_write, mem_wb_wr_data, stall
    );

    modport slave (
        input  ex_valid, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_alu_result, ex_store_data, flush, dmem_ready, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
               ex_mem_rd_addr, ex_mem_reg_write, ex_mem_fwd_data,
               mem_wb_rd_addr, mem_wb_reg_write, mem_wb_wr_data, stall
    );
endinterface

// File: rtl/ex_mem_wb_regs.sv
// ex_mem_wb_regs
//   EX/MEM and MEM/WB pipeline registers with a data-memory handshake.
//   A memory op held in EX/MEM requests the memory until dmem_ready; while
//   waiting, stall freezes the front end, EX/MEM holds and MEM/WB gets bubbles.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears both registers to bubbles)
//   bus   : ex_mem_wb_regs_if.slave (EX inputs, dmem bus, forwarding outputs)
module ex_mem_wb_regs #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    ex_mem_wb_regs_if.slave    bus
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t          r_state;

    // EX/MEM register
    logic            r_em_valid;
    logic [4:0]      r_em_rd;
    logic            r_em_reg_write;
    logic            r_em_mem_read;
    logic            r_em_mem_write;
    logic [XLEN-1:0] r_em_alu;
    logic [XLEN-1:0] r_em_store;

    // MEM/WB register
    logic [4:0]      r_wb_rd;
    logic            r_wb_reg_write;
    logic [XLEN-1:0] r_wb_data;

    logic            w_mem_op;
    logic            w_stall;
    logic            w_take_ex;

    assign w_mem_op  = r_em_valid & (r_em_mem_read | r_em_mem_write);
    assign w_stall   = w_mem_op & ~bus.dmem_ready;
    assign w_take_ex = bus.ex_valid & ~bus.flush;

    assign bus.dmem_req   = w_mem_op;
    assign bus.dmem_we    = r_em_valid & r_em_mem_write;
    assign bus.dmem_addr  = r_em_alu;
    assign bus.dmem_wdata = r_em_store;
    assign bus.stall      = w_stall;

    // Loads are never forwarded from EX/MEM: their data does not exist yet.
    assign bus.ex_mem_rd_addr   = r_em_rd;
    assign bus.ex_mem_reg_write = r_em_valid & r_em_reg_write & ~r_em_mem_read
                                  & (r_em_rd != 5'd0);
    assign bus.ex_mem_fwd_data  = r_em_alu;

    assign bus.mem_wb_rd_addr   = r_wb_rd;
    assign bus.mem_wb_reg_write = r_wb_reg_write;
    assign bus.mem_wb_wr_data   = r_wb_data;

    // EX/MEM: hold while stalled (flush ignored), else take EX or a bubble.
    // Bubbles clear every field so a dead slot never shows stale values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_em_valid     <= 1'b0;
            r_em_rd        <= '0;
            r_em_reg_write <= 1'b0;
            r_em_mem_read  <= 1'b0;
            r_em_mem_write <= 1'b0;
            r_em_alu       <= '0;
            r_em_store     <= '0;
        end else if (!w_stall) begin
            if (w_take_ex) begin
                r_em_valid     <= 1'b1;
                r_em_rd        <= bus.ex_rd_addr;
                r_em_reg_write <= bus.ex_reg_write;
                r_em_mem_read  <= bus.ex_mem_read;
                r_em_mem_write <= bus.ex_mem_write;
                r_em_alu       <= bus.ex_alu_result;
                r_em_store     <= bus.ex_store_data;
            end else begin
                r_em_valid     <= 1'b0;
                r_em_rd        <= '0;
                r_em_reg_write <= 1'b0;
                r_em_mem_read  <= 1'b0;
                r_em_mem_write <= 1'b0;
                r_em_alu       <= '0;
                r_em_store     <= '0;
            end
        end
    end

    // MEM/WB: bubble while stalled; otherwise retire EX/MEM. Stores never
    // write the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_rd        <= '0;
            r_wb_reg_write <= 1'b0;
            r_wb_data      <= '0;
        end else if (w_stall) begin
            r_wb_rd        <= '0;
            r_wb_reg_write <= 1'b0;
            r_wb_data      <= '0;
        end else begin
            r_wb_rd        <= r_em_rd;
            r_wb_reg_write <= r_em_valid & r_em_reg_write & ~r_em_mem_write
                              & (r_em_rd != 5'd0);
            r_wb_data      <= (r_em_valid & r_em_mem_read) ? bus.dmem_rdata
                                                           : r_em_alu;
        end
    end

    // Memory-wait tracker; reset abandons an outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:     if (w_mem_op && !bus.dmem_ready) r_state <= WAIT_MEM;
                WAIT_MEM: if (bus.dmem_ready)              r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
        end
    end

    // While waiting, the held EX/MEM op must still be requesting memory.
    a_wait_holds_req: assert property (
        @(posedge clk) disable iff (!rst_n)
        (r_state == WAIT_MEM) |-> bus.dmem_req
    );

endmodule

// File: tb/tb_ex_mem_wb_regs.sv
module tb_ex_mem_wb_regs;

    logic clk;
    logic rst_n;

    ex_mem_wb_regs_if #(.XLEN(32)) bus ();

    ex_mem_wb_regs #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // def = the slot's field values are defined (real op, stall bubble or reset).
    typedef struct packed {
        logic        def;
        logic        valid;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] sd;
    } em_t;

    typedef struct packed {
        logic        def;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } wb_t;

    em_t  m_em;
    wb_t  m_wb;
    logic m_busy;

    // Memory is "busy" whenever a real load/store sits in EX/MEM and the
    // memory has not answered yet.
    assign m_busy = m_em.valid && (m_em.mr || m_em.mw) && !bus.dmem_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_em <= '{def: 1'b1, default: '0};
            m_wb <= '{def: 1'b1, default: '0};
        end else if (m_busy) begin
            m_wb <= '{def: 1'b1, default: '0};
        end else begin
            if (m_em.valid)
                m_wb <= '{def: 1'b1, rd: m_em.rd,
                          we: m_em.rw && !m_em.mw && (m_em.rd != 0),
                          data: m_em.mr ? bus.dmem_rdata : m_em.alu};
            else
                m_wb <= '{def: 1'b0, default: '0};
            if (bus.ex_valid && !bus.flush)
                m_em <= '{def: 1'b1, valid: 1'b1, rd: bus.ex_rd_addr,
                          rw: bus.ex_reg_write, mr: bus.ex_mem_read,
                          mw: bus.ex_mem_write, alu: bus.ex_alu_result,
                          sd: bus.ex_store_data};
            else
                m_em <= '{def: 1'b0, default: '0};
        end
    end

    // Every-cycle comparison, away from the clock edge.
    always @(negedge clk) begin
        logic e_req;
        e_req = m_em.valid && (m_em.mr || m_em.mw);
        chk("dmem_req", 32'(bus.dmem_req), 32'(e_req));
        chk("dmem_we", 32'(bus.dmem_we), 32'(m_em.valid && m_em.mw));
        chk("stall", 32'(bus.stall), 32'(e_req && !bus.dmem_ready));
        chk("ex_mem_reg_write", 32'(bus.ex_mem_reg_write),
            32'(m_em.valid && m_em.rw && !m_em.mr && m_em.rd != 0));
        chk("mem_wb_reg_write", 32'(bus.mem_wb_reg_write), 32'(m_wb.we));
        if (m_em.def) begin
            chk("dmem_addr", bus.dmem_addr, m_em.alu);
            chk("dmem_wdata", bus.dmem_wdata, m_em.sd);
            chk("ex_mem_rd_addr", 32'(bus.ex_mem_rd_addr), 32'(m_em.rd));
            chk("ex_mem_fwd_data", bus.ex_mem_fwd_data, m_em.alu);
        end
        if (m_wb.def) begin
            chk("mem_wb_rd_addr", 32'(bus.mem_wb_rd_addr), 32'(m_wb.rd));
            chk("mem_wb_wr_data", bus.mem_wb_wr_data, m_wb.data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic v, input logic [4:0] rd, input logic rw,
                      input logic mr, input logic mw, input logic [31:0] alu,
                      input logic [31:0] sd, input logic fl, input logic rdy,
                      input logic [31:0] rdata);
        bus.ex_valid      = v;
        bus.ex_rd_addr    = rd;
        bus.ex_reg_write  = rw;
        bus.ex_mem_read   = mr;
        bus.ex_mem_write  = mw;
        bus.ex_alu_result = alu;
        bus.ex_store_data = sd;
        bus.flush         = fl;
        bus.dmem_ready    = rdy;
        bus.dmem_rdata    = rdata;
    endtask

    task automatic idle(input logic rdy);
        op(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, rdy, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle(1'b0);
        #3;
        chk("reset dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("reset stall", 32'(bus.stall), 32'd0);
        chk("reset mem_wb_wr_data", bus.mem_wb_wr_data, 32'd0);
        #9 rst_n = 1'b1;

        // ALU op flows EX/MEM then MEM/WB
        step(); op(1, 5'd5, 1, 0, 0, 32'h1234, 32'h0, 0, 0, 32'h0);
        step(); idle(0); #1;
        chk("alu em rd", 32'(bus.ex_mem_rd_addr), 32'd5);
        chk("alu em rw", 32'(bus.ex_mem_reg_write), 32'd1);
        chk("alu em fwd", bus.ex_mem_fwd_data, 32'h1234);
        step(); idle(0); #1;
        chk("alu wb rd", 32'(bus.mem_wb_rd_addr), 32'd5);
        chk("alu wb rw", 32'(bus.mem_wb_reg_write), 32'd1);
        chk("alu wb data", bus.mem_wb_wr_data, 32'h1234);

        // Load with three wait cycles
        step(); op(1, 5'd7, 1, 1, 0, 32'h100, 32'h0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(); op(1, 5'd2, 1, 0, 0, 32'h9, 32'h0, 0, 0, 32'h0); #1;
            chk("load stall", 32'(bus.stall), 32'd1);
            chk("load em rw", 32'(bus.ex_mem_reg_write), 32'd0);
            chk("load addr", bus.dmem_addr, 32'h100);
            chk("load wb bubble", 32'(bus.mem_wb_reg_write), 32'd0);
        end
        step(); idle(1); bus.dmem_rdata = 32'hCAFE; #1;
        chk("load done stall", 32'(bus.stall), 32'd0);
        chk("load third bubble rd", 32'(bus.mem_wb_rd_addr), 32'd0);
        step(); idle(0); #1;
        chk("load wb data", bus.mem_wb_wr_data, 32'hCAFE);
        chk("load wb rd", 32'(bus.mem_wb_rd_addr), 32'd7);
        chk("load wb rw", 32'(bus.mem_wb_reg_write), 32'd1);

        // rd = 0 never writes
        step(); op(1, 5'd0, 1, 0, 0, 32'hABCD, 32'h0, 0, 0, 32'h0);
        step(); idle(0); #1;
        chk("rd0 em rw", 32'(bus.ex_mem_reg_write), 32'd0);
        step(); idle(0); #1;
        chk("rd0 wb rw", 32'(bus.mem_wb_reg_write), 32'd0);

        // Store completing in its first MEM cycle (ready while idle is ignored)
        step(); op(1, 5'd3, 0, 0, 1, 32'h20, 32'h55, 0, 1, 32'h0);
        step(); idle(1); #1;
        chk("store req", 32'(bus.dmem_req), 32'd1);
        chk("store we", 32'(bus.dmem_we), 32'd1);
        chk("store addr", bus.dmem_addr, 32'h20);
        chk("store wdata", bus.dmem_wdata, 32'h55);
        chk("store stall", 32'(bus.stall), 32'd0);
        step(); idle(0); #1;
        chk("store req gone", 32'(bus.dmem_req), 32'd0);
        chk("store wb rw", 32'(bus.mem_wb_reg_write), 32'd0);

        // Flush of a valid op, then flush ignored during a stall
        step(); op(1, 5'd3, 1, 0, 0, 32'h99, 32'h0, 1, 0, 32'h0);
        step(); op(1, 5'd9, 1, 1, 0, 32'h40, 32'h0, 0, 0, 32'h0); #1;
        chk("flush em rw", 32'(bus.ex_mem_reg_write), 32'd0);
        chk("flush req", 32'(bus.dmem_req), 32'd0);
        step(); op(1, 5'd4, 1, 0, 0, 32'h11, 32'h0, 1, 0, 32'h0); #1;
        chk("flush stall", 32'(bus.stall), 32'd1);
        step(); op(1, 5'd4, 1, 0, 0, 32'h11, 32'h0, 1, 1, 32'hBEEF); #1;
        chk("flush held addr", bus.dmem_addr, 32'h40);
        step(); idle(0); #1;
        chk("flush wb data", bus.mem_wb_wr_data, 32'hBEEF);
        chk("flush wb rd", 32'(bus.mem_wb_rd_addr), 32'd9);
        chk("flush after em rw", 32'(bus.ex_mem_reg_write), 32'd0);

        // Asynchronous reset in the middle of a memory wait
        step(); op(1, 5'd11, 1, 1, 0, 32'h80, 32'h0, 0, 0, 32'h0);
        step(); idle(0); #1;
        chk("rst pre stall", 32'(bus.stall), 32'd1);
        #1 rst_n = 1'b0; #1;
        chk("rst req", 32'(bus.dmem_req), 32'd0);
        chk("rst stall", 32'(bus.stall), 32'd0);
        chk("rst addr", bus.dmem_addr, 32'd0);
        chk("rst wb rw", 32'(bus.mem_wb_reg_write), 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        step(); op(1, 5'd6, 1, 0, 0, 32'h77, 32'h0, 0, 0, 32'h0);
        step(); idle(0); #1;
        chk("post rst em fwd", bus.ex_mem_fwd_data, 32'h77);
        step(); idle(0); #1;
        chk("post rst wb data", bus.mem_wb_wr_data, 32'h77);
        chk("post rst wb rd", 32'(bus.mem_wb_rd_addr), 32'd6);

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 800; n++) begin
            int unsigned kind;
            logic mr, mw, rw;
            step();
            kind = $urandom_range(0, 3);
            mr = (kind == 1);
            mw = (kind == 2);
            rw = mw ? 1'b0 : 1'($urandom);
            op(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), rw, mr, mw,
               $urandom, $urandom, 1'($urandom_range(0, 5) == 0),
               1'($urandom_range(0, 2) != 0), $urandom);
        end
        step(); idle(1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_wb_regs.md
EX_MEM_WB_REGS -- requirements
Module: ex_mem_wb_regs

Interface
REQ-001 Parameter: XLEN, default 32, data/address width.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 ex_valid  in  1  EX stage holds a real instruction.
REQ-005 ex_rd_addr  in  5  EX destination register.
REQ-006 ex_reg_write  in  1  EX instruction writes rd.
REQ-007 ex_mem_read / ex_mem_write  in  1 each  EX instruction is load / store.
REQ-008 ex_alu_result  in  XLEN  ALU result / memory address.
REQ-009 ex_store_data  in  XLEN  store data.
REQ-010 flush  in  1  insert bubble into EX/MEM instead of EX contents.
REQ-011 dmem_req, dmem_we  out  1 each  memory request / write enable.
REQ-012 dmem_addr, dmem_wdata  out  XLEN each  memory address / write data.
REQ-013 dmem_ready  in  1  memory completes current request this cycle.
REQ-014 dmem_rdata  in  XLEN  load data, valid when dmem_ready=1.
REQ-015 ex_mem_rd_addr  out  5; ex_mem_reg_write  out  1; ex_mem_fwd_data  out  XLEN: EX/MEM forwarding source.
REQ-016 mem_wb_rd_addr  out  5; mem_wb_reg_write  out  1; mem_wb_wr_data  out  XLEN: MEM/WB forwarding source and register-file write port.
REQ-017 stall  out  1  freeze PC, IF/ID, ID/EX this cycle.

Function
REQ-018 EX/MEM register SHALL hold valid, rd, reg_write, mem_read, mem_write, alu_result, store_data.
REQ-019 FSM states SHALL be IDLE and WAIT_MEM.
REQ-020 IDLE -> WAIT_MEM when EX/MEM valid memory op present and dmem_ready=0; WAIT_MEM -> IDLE on dmem_ready=1; other cases stay.
REQ-021 dmem_req SHALL equal EX/MEM valid AND (mem_read OR mem_write), combinational, in both states; dmem_we = valid AND mem_write; dmem_addr = alu_result; dmem_wdata = store_data.
REQ-022 stall SHALL equal dmem_req AND NOT dmem_ready (combinational; single-cycle ops never stall).
REQ-023 When stall=0, EX/MEM SHALL capture EX inputs, or a bubble (valid=0) if flush=1 or ex_valid=0.
REQ-024 When stall=1, EX/MEM SHALL hold its contents; flush SHALL be ignored.
REQ-025 ex_mem_reg_write SHALL be valid AND reg_write AND NOT mem_read AND (rd != 0); load data never forwarded from EX/MEM.
REQ-026 ex_mem_fwd_data SHALL equal EX/MEM alu_result; ex_mem_rd_addr SHALL equal EX/MEM rd.
REQ-027 When stall=0, MEM/WB SHALL capture EX/MEM: wr_data = dmem_rdata if load else alu_result; reg_write = valid AND reg_write AND (rd != 0).
REQ-028 When stall=1, MEM/WB SHALL load a bubble (reg_write=0, rd=0, data=0).
REQ-029 ALU result SHALL appear on mem_wb outputs exactly 1 cycle after EX/MEM; load result 1 cycle after the dmem_ready=1 cycle.
REQ-030 Store SHALL produce mem_wb_reg_write=0.
REQ-031 dmem_ready while dmem_req=0 SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL immediately clear both registers to bubble, all outputs 0, FSM to IDLE, regardless of clk.
REQ-033 Reset during WAIT_MEM SHALL abandon the request; dmem_req=0 from reset assertion.
REQ-034 First edge after rst_n release SHALL behave as IDLE with empty pipeline.

Verification
REQ-035 ALU op rd=5, result 0x1234 -> next cycle ex_mem_rd_addr=5, ex_mem_reg_write=1, fwd 0x1234; following cycle mem_wb_rd_addr=5, reg_write=1, data 0x1234.
REQ-036 Load rd=7, addr 0x100, dmem_ready low 3 cycles then high with rdata 0xCAFE -> stall=1 for 3 cycles, ex_mem_reg_write=0 throughout, three MEM/WB bubbles, then mem_wb data 0xCAFE rd=7.
REQ-037 ALU op with rd=0 -> ex_mem_reg_write=0 and mem_wb_reg_write=0.
REQ-038 Store addr 0x20 data 0x55, dmem_ready=1 same cycle -> dmem_req=dmem_we=1 one cycle, stall=0, mem_wb_reg_write=0.
REQ-039 flush=1 with valid EX op -> EX/MEM bubble; flush=1 during stall -> ignored, stalled op completes.
REQ-040 rst_n low mid-WAIT_MEM -> all outputs 0 asynchronously; after release, new ALU op flows normally.
